// File: rtl/ringosc_freq_meter_if.sv
// Control/result bundle between a host and the ring-oscillator frequency meter.
// The host drives start/gate_len; the meter returns busy/done and the held result.
interface ringosc_freq_meter_if #(
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16
);
    logic              start;
    logic [GATE_W-1:0] gate_len;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output start, gate_len,
        input  busy, done, count, overflow
    );

    modport slave (
        input  start, gate_len,
        output busy, done, count, overflow
    );
endinterface

// File: rtl/ringosc_freq_meter.sv
// Gated edge counter for an async ring-oscillator tap; result held until the next done.
// Latency: start seen in cycle T -> done in cycle T+gate_len+1; no backpressure, start ignored while busy.
// RINGOSC_FREQ_AUTORUN_EN: DONE reloads the window and keeps measuring instead of returning to IDLE.
module ringosc_freq_meter #(
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                osc_in,
    ringosc_freq_meter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_s1;
    logic              r_s2;
    logic              r_s3;
    logic              w_edge;
    logic [GATE_W-1:0] r_gate_rem;
    logic [GATE_W-1:0] w_gate_rem;
    logic [CNT_W-1:0]  r_acc;
    logic [CNT_W-1:0]  w_acc;
    logic [CNT_W-1:0]  r_count;
    logic              r_sat;
    logic              w_sat;
    logic              r_ovf;
    logic              r_busy;
    logic              r_done;

    assign w_edge = r_s2 & ~r_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= osc_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_gate_rem = r_gate_rem;
        w_acc      = r_acc;
        w_sat      = r_sat;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_gate_rem = bus.gate_len;
                    w_acc      = '0;
                    w_sat      = 1'b0;
                    w_next     = (bus.gate_len != '0) ? S_COUNT : S_DONE;
                end
            end
            S_COUNT: begin
                if (w_edge) begin
                    if (r_acc != '1) begin
                        w_acc = r_acc + CNT_W'(1);
                    end else begin
                        w_sat = 1'b1;
                    end
                end
                w_gate_rem = r_gate_rem - GATE_W'(1);
                if (r_gate_rem == GATE_W'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
`ifdef RINGOSC_FREQ_AUTORUN_EN
                w_gate_rem = bus.gate_len;
                w_acc      = '0;
                w_sat      = 1'b0;
                w_next     = (bus.gate_len != '0) ? S_COUNT : S_IDLE;
`else
                w_next     = S_IDLE;
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Result is captured on the edge entering DONE so the final COUNT-cycle edge is included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gate_rem <= '0;
            r_acc      <= '0;
            r_sat      <= 1'b0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_gate_rem <= w_gate_rem;
            r_acc      <= w_acc;
            r_sat      <= w_sat;
            r_busy     <= (w_next != S_IDLE);
            r_done     <= (w_next == S_DONE);
            if (w_next == S_DONE) begin
                r_count <= w_acc;
                r_ovf   <= w_sat;
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.count    = r_count;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_ringosc_freq_meter.sv
`timescale 1ns/1ps
// Scoreboarded bench: stimulus pushes expected windows, a negedge monitor checks busy/done/results.
module tb_ringosc_freq_meter;
    localparam int CNT_W  = 8;
    localparam int GATE_W = 16;
    localparam int MAXC   = (1 << CNT_W) - 1;
`ifdef RINGOSC_FREQ_AUTORUN_EN
    localparam bit AUTORUN = 1'b1;
`else
    localparam bit AUTORUN = 1'b0;
`endif

    typedef struct {
        int t;
        int n;
        int lo;
        int hi;
        bit ovf_known;
        bit ovf;
    } exp_t;

    logic    clk;
    logic    rst_n;
    logic    osc_in;
    int      cyc;
    int      checks;
    int      errors;
    exp_t    sb[$];
    int      cur_t;
    int      cur_n;
    int      cur_p;
    bit      active;
    int      idle_cyc;
    realtime osc_half;

    ringosc_freq_meter_if #(.CNT_W(CNT_W), .GATE_W(GATE_W)) bus ();

    ringosc_freq_meter #(.CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc_in),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oscillator is slightly off the clock grid so its phase drifts against clk.
    initial begin
        osc_in = 1'b0;
        #3.3;
        forever begin
            #(osc_half);
            osc_in = ~osc_in;
        end
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    // Rising edges in n cycles at period p is floor or ceil of n/p; allow one more for sync phase.
    function automatic exp_t make_exp(input int t, input int n, input int p);
        exp_t e;
        int   rlo;
        int   rhi;
        rlo = n / p - 1;
        if (rlo < 0) rlo = 0;
        rhi = (n + p - 1) / p + 1;
        if (n == 0) begin
            rlo = 0;
            rhi = 0;
        end
        e.t         = t;
        e.n         = n;
        e.ovf_known = (rlo > MAXC) || (rhi <= MAXC);
        e.ovf       = (rlo > MAXC);
        e.lo        = (rlo > MAXC) ? MAXC : rlo;
        e.hi        = (rhi > MAXC) ? MAXC : rhi;
        return e;
    endfunction

    always @(negedge clk) begin
        bit exp_busy;
        bit exp_done;
        exp_t e;
        if (!rst_n) begin
            check_eq("rst_busy", int'(bus.busy), 0);
            check_eq("rst_done", int'(bus.done), 0);
            check_eq("rst_count", int'(bus.count), 0);
            check_eq("rst_overflow", int'(bus.overflow), 0);
        end else begin
            if (AUTORUN) begin
                exp_busy = active && (cyc >= cur_t + 1);
                exp_done = active && (cyc > cur_t) && (((cyc - cur_t) % (cur_n + 1)) == 0);
            end else begin
                exp_busy = active && (cyc >= cur_t + 1) && (cyc <= cur_t + cur_n + 1);
                exp_done = active && (cyc == cur_t + cur_n + 1);
            end
            check_eq("busy", int'(bus.busy), int'(exp_busy));
            check_eq("done", int'(bus.done), int'(exp_done));
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d count=%0d", cyc, bus.count);
                end else begin
                    e = sb.pop_front();
                    check_eq("done_latency", cyc - e.t, e.n + 1);
                    checks++;
                    if (int'(bus.count) < e.lo || int'(bus.count) > e.hi) begin
                        errors++;
                        $display("FAIL count cyc=%0d got=%0d exp=%0d..%0d", cyc, bus.count, e.lo, e.hi);
                    end
                    if (e.ovf_known) check_eq("overflow", int'(bus.overflow), int'(e.ovf));
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_period(input int p);
        if (p != cur_p) begin
            cur_p    = p;
            osc_half = 5.0 * p + 0.037;
            repeat (2 * p + 4) @(posedge clk);
        end
    endtask

    task automatic expect_window(input int t, input int n);
        sb.push_back(make_exp(t, n, cur_p));
        cur_t    = t;
        cur_n    = n;
        active   = 1'b1;
        idle_cyc = t + n + 2;
    endtask

    task automatic issue(input int n);
        @(posedge clk);
        #1;
        wait_until(idle_cyc);
        bus.gate_len = GATE_W'(n);
        bus.start    = 1'b1;
        expect_window(cyc, n);
    endtask

    task automatic drop_start();
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.gate_len = GATE_W'($urandom);
    endtask

    task automatic run(input int n, input int p);
        set_period(p);
        issue(n);
        drop_start();
        wait_until(cur_t + cur_n + 3);
    endtask

    task automatic reset_now(input int hold);
        rst_n  = 1'b0;
        active = 1'b0;
        sb.delete();
        repeat (hold) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        idle_cyc = cyc;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        active       = 1'b0;
        cur_t        = 0;
        cur_n        = 0;
        cur_p        = 8;
        idle_cyc     = 0;
        osc_half     = 40.037;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.gate_len = '0;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus.start    = 1'($urandom);
            bus.gate_len = GATE_W'($urandom);
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        idle_cyc = cyc;
        repeat (10) @(posedge clk);

`ifdef RINGOSC_FREQ_AUTORUN_EN
        set_period(10);
        issue(100);
        drop_start();
        for (int k = 1; k < 4; k++) sb.push_back(make_exp(cur_t + k * 101, 100, cur_p));
        wait_until(cur_t + 4 * 101 + 3);
        check_eq("autorun_all_done", sb.size(), 0);
        reset_now(3);
        repeat (12) @(posedge clk);
`else
        run(800, 8);
        run(0, 8);
        run(2000, 4);
        run(40, 4);

        set_period(8);
        issue(800);
        drop_start();
        wait_until(cur_t + 100);
        bus.start    = 1'b1;
        bus.gate_len = GATE_W'(5);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_until(cur_t + cur_n + 3);

        issue(800);
        drop_start();
        wait_until(cur_t + 300);
        reset_now(5);
        repeat (12) @(posedge clk);

        // start held high across DONE restarts after exactly one IDLE cycle
        issue(60);
        wait_until(cur_t + 62);
        expect_window(cyc, 60);
        drop_start();
        wait_until(cur_t + cur_n + 3);

        for (int i = 0; i < 8; i++) begin
            run(int'($urandom_range(1, 300)), int'($urandom_range(4, 12)));
        end
`endif
        repeat (5) @(posedge clk);
        #1;
        check_eq("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ringosc_freq_meter.md
# ringosc_freq_meter

Gated frequency counter that measures a free-running ring-oscillator tap in the system clock domain. It sits downstream of the inverter-chain oscillator, takes one tap as an asynchronous input, and counts its rising edges over a programmable window of `clk` cycles. The result is held on a parallel bus for readout through the dedicated outputs or the bidirectional IOs.

## Interface
Parameters:
- `CNT_W`, default 16: width of the edge counter and the result.
- `GATE_W`, default 16: width of the gate-length input.

Ports:
- `clk`  input  1  system clock; all state is on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `osc_in`  input  1  oscillator tap; asynchronous to `clk`.
- `start`  input  1  request a measurement; sampled only in IDLE.
- `gate_len`  input  GATE_W  window length in `clk` cycles; latched when `start` is accepted.
- `busy`  output  1  high from the accepting edge until `done`, inclusive.
- `done`  output  1  one-cycle pulse when `count` updates.
- `count`  output  CNT_W  rising edges counted in the last window; held until the next `done`.
- `overflow`  output  1  last window saturated; updates with `count`.

## Operation
- Input conditioning:
  - `osc_in` passes through a 2-flop synchronizer (s1, s2) and then a delay flop s3.
  - The edge strobe is `edge = s2 & ~s3`. It is combinational from flops and runs in every state.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - `busy` = 0.
  - `start` = 1 latches `gate_len` into `gate_rem` and clears `acc` and `sat`.
  - Next state is COUNT if `gate_len` != 0, and DONE if `gate_len` == 0.
- COUNT:
  - Lasts exactly `gate_len` cycles.
  - On each cycle with `edge` = 1: `acc` increments if `acc` != all-ones. Otherwise `acc` holds and `sat` is set.
  - `gate_rem` decrements every cycle. At `gate_rem` == 1 the next state is DONE.
- DONE:
  - Lasts one cycle.
  - `count` <= `acc`, `overflow` <= `sat`, `done` = 1.
  - Next state is IDLE.
- Arithmetic:
  - `acc` is CNT_W bits and saturating. It never wraps.
  - `gate_rem` is GATE_W bits.
- Boundary conditions:
  - `start` while `busy` = 1 is ignored and not queued. `gate_len` changes during a window have no effect.
  - An edge in the same cycle as the IDLE→COUNT transition is not counted. An edge in the last COUNT cycle is counted.
  - `osc_in` frequency must be below f_clk/2 for exact counts. Above that, edges are silently lost and no error is flagged.
  - Asserting `rst_n` low mid-window immediately clears all state and outputs. No `done` is produced.

## Timing
- Reset values: state IDLE; `busy`, `done`, `overflow` = 0; `count` = 0; synchronizer flops 0.
- Synchronizer latency: an `osc_in` rising edge appears on `edge` 2–3 `clk` cycles later.
- Latency from `start` accepted at edge T:
  - COUNT occupies T+1 … T+N, where N = `gate_len`.
  - DONE is registered at T+N+1: `done`, `count` and `overflow` are valid after that edge.
  - `busy` is high from T+1 through T+N+1.
- With `gate_len` = 0: DONE at T+1, `count` = 0, `overflow` = 0.
- `done` and `busy` are registered outputs (state decode from flops, glitch-free).
- Back-to-back: `start` held high restarts on the cycle after DONE (IDLE lasts one cycle).

## Configuration
- `RINGOSC_FREQ_AUTORUN_EN`:
  - Defined: DONE transitions directly to COUNT, reloading `gate_rem` from the current `gate_len` and clearing `acc` and `sat`. Measurement repeats continuously with no IDLE gap, and `busy` stays high. `start` is needed only to leave IDLE after reset. If `gate_len` = 0 at reload, the next state is IDLE.
  - Undefined: DONE always returns to IDLE, as described above.

## Test plan
- Reset:
  - Stimulus: hold `rst_n` = 0 with random `osc_in` and `start`.
  - Response: `busy` = `done` = `overflow` = 0 and `count` = 0 throughout; `done` stays 0 for 10 cycles after release.
- Basic count:
  - Stimulus: `osc_in` period 8 clk (4 high, 4 low) async-phased; `gate_len` = 800; one `start` pulse.
  - Response: `done` exactly 801 cycles after the accepting edge; `count` ∈ {99,100,101}; `overflow` = 0.
- Zero gate:
  - Stimulus: `gate_len` = 0; `start` pulse.
  - Response: `done` on the next cycle; `count` = 0; `busy` high for exactly 1 cycle.
- Saturation:
  - Stimulus: CNT_W = 8, `osc_in` period 4 clk, `gate_len` = 2000.
  - Response: `count` = 255, `overflow` = 1.
  - Follow-up: a rerun with `gate_len` = 40 gives `count` ≈ 10, `overflow` = 0.
- Ignored start and reset mid-run:
  - Stimulus: re-pulse `start` with `gate_len` = 5 at cycle 100 of a 800-cycle window.
  - Response: the window still ends at 801 cycles.
  - Stimulus: drop `rst_n` at cycle 300 of the next window.
  - Response: all outputs 0 immediately, no `done`.
- Autorun (`RINGOSC_FREQ_AUTORUN_EN` defined):
  - Stimulus: `gate_len` = 100, single `start`, `osc_in` period 10.
  - Response: `done` every 101 cycles with `count` ∈ {9,10,11}; `busy` continuously 1.
